// File: rtl/uart_program_loader_if.sv
// Loader-side bundle: UART RX FIFO pop port, program-memory write port and CPU run/debug handshake.
// master = the loader, slave = the surrounding system (FIFO, PM, MIPS core, debug unit).
interface uart_program_loader_if #(
    parameter int PM_ADDR_W = 5
);
    logic                 I_RX_EMPTY;
    logic [7:0]           I_RX_DATA;
    logic                 O_RD_UART;
    logic                 O_PM_WR;
    logic [PM_ADDR_W-1:0] O_PM_ADDR;
    logic [31:0]          O_PM_DATA;
    logic                 O_LOAD_DONE;
    logic                 O_CPU_EN;
    logic                 I_HALT;
    logic                 O_SEND_REQ;
    logic                 I_SEND_DONE;
    logic                 O_ERR;

    modport master (
        input  I_RX_EMPTY, I_RX_DATA, I_HALT, I_SEND_DONE,
        output O_RD_UART, O_PM_WR, O_PM_ADDR, O_PM_DATA,
               O_LOAD_DONE, O_CPU_EN, O_SEND_REQ, O_ERR
    );

    modport slave (
        output I_RX_EMPTY, I_RX_DATA, I_HALT, I_SEND_DONE,
        input  O_RD_UART, O_PM_WR, O_PM_ADDR, O_PM_DATA,
               O_LOAD_DONE, O_CPU_EN, O_SEND_REQ, O_ERR
    );
endinterface

// File: rtl/uart_program_loader.sv
// UART program loader: reads N, loads N MSB-first 32-bit words into MIPS program memory, then runs/steps the CPU.
// Optional inter-byte timeout in RECEIVE_INSTR is enabled by defining LOADER_TIMEOUT_EN.
module uart_program_loader #(
    parameter int          PM_ADDR_W      = 5,
    parameter logic [7:0]  CMD_RUN        = 8'h72,
    parameter logic [7:0]  CMD_DEBUG      = 8'h64,
    parameter logic [7:0]  CMD_STEP       = 8'h73,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input logic                   CLK,
    input logic                   RESET,
    uart_program_loader_if.master bus
);
    // Word index must hold N-1 (up to 254) and also the first out-of-range index.
    localparam int IDX_W = (PM_ADDR_W >= 8) ? PM_ADDR_W + 1 : 9;
    localparam logic [IDX_W-1:0] DEPTH = IDX_W'(2 ** PM_ADDR_W);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << 26)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 26-bit timeout counter");
    end

    typedef enum logic [2:0] {
        WAIT_N,
        RECEIVE_INSTR,
        LOAD_PM,
        WAIT_OP,
        RUN,
        SEND_RUN,
        DEBUG,
        SEND_DEBUG
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       n_q, n_d;
    logic [IDX_W-1:0] word_q, word_d;
    logic [1:0]       byte_q, byte_d;
    logic [31:0]      shreg_q, shreg_d;
    logic             step_q, step_d;
    logic             send_req_q, send_req_d;
    logic             rd;
    logic             timeout;
    logic             pm_wr;
    logic             err;

    assign rd = (state_q inside {WAIT_N, RECEIVE_INSTR, WAIT_OP, DEBUG}) && !bus.I_RX_EMPTY && !RESET;

`ifdef LOADER_TIMEOUT_EN
    localparam logic [25:0] TO_LAST = 26'(TIMEOUT_CYCLES - 1);
    logic [25:0] to_cnt_q;

    assign timeout = (state_q == RECEIVE_INSTR) && !rd && (to_cnt_q == TO_LAST);

    always_ff @(posedge CLK) begin
        if (RESET || state_q != RECEIVE_INSTR || rd || timeout)
            to_cnt_q <= '0;
        else
            to_cnt_q <= to_cnt_q + 26'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_d     = word_q;
        byte_d     = byte_q;
        shreg_d    = shreg_q;
        step_d     = 1'b0;
        send_req_d = 1'b0;
        pm_wr      = 1'b0;
        err        = 1'b0;

        case (state_q)
            WAIT_N: begin
                if (rd) begin
                    if (bus.I_RX_DATA == 8'h00) begin
                        err = 1'b1;
                    end else begin
                        n_d     = bus.I_RX_DATA;
                        word_d  = '0;
                        byte_d  = '0;
                        state_d = RECEIVE_INSTR;
                    end
                end
            end
            RECEIVE_INSTR: begin
                if (timeout) begin
                    err     = 1'b1;
                    word_d  = '0;
                    byte_d  = '0;
                    state_d = WAIT_N;
                end else if (rd) begin
                    shreg_d = {shreg_q[23:0], bus.I_RX_DATA};
                    byte_d  = byte_q + 2'd1;
                    if (byte_q == 2'd3)
                        state_d = LOAD_PM;
                end
            end
            LOAD_PM: begin
                // Words past the PM depth are still counted so the stream stays aligned.
                pm_wr   = (word_q < DEPTH);
                err     = (word_q == DEPTH);
                word_d  = word_q + IDX_W'(1);
                state_d = (word_d == IDX_W'(n_q)) ? WAIT_OP : RECEIVE_INSTR;
            end
            WAIT_OP: begin
                if (rd) begin
                    if (bus.I_RX_DATA == CMD_RUN)
                        state_d = RUN;
                    else if (bus.I_RX_DATA == CMD_DEBUG)
                        state_d = DEBUG;
                    else
                        err = 1'b1;
                end
            end
            RUN: begin
                if (bus.I_HALT) begin
                    state_d    = SEND_RUN;
                    send_req_d = 1'b1;
                end
            end
            SEND_RUN: begin
                if (bus.I_SEND_DONE)
                    state_d = WAIT_N;
            end
            DEBUG: begin
                // step_q marks the single enabled cycle; the dump request follows it.
                if (step_q) begin
                    state_d    = SEND_DEBUG;
                    send_req_d = 1'b1;
                end else if (rd && bus.I_RX_DATA == CMD_STEP) begin
                    step_d = 1'b1;
                end
            end
            SEND_DEBUG: begin
                if (bus.I_SEND_DONE)
                    state_d = bus.I_HALT ? WAIT_N : DEBUG;
            end
            default: state_d = WAIT_N;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= WAIT_N;
            n_q        <= '0;
            word_q     <= '0;
            byte_q     <= '0;
            shreg_q    <= '0;
            step_q     <= 1'b0;
            send_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            word_q     <= word_d;
            byte_q     <= byte_d;
            shreg_q    <= shreg_d;
            step_q     <= step_d;
            send_req_q <= send_req_d;
        end
    end

    assign bus.O_RD_UART   = rd;
    assign bus.O_PM_WR     = pm_wr && !RESET;
    assign bus.O_PM_ADDR   = word_q[PM_ADDR_W-1:0];
    assign bus.O_PM_DATA   = shreg_q;
    assign bus.O_LOAD_DONE = state_q inside {WAIT_OP, RUN, SEND_RUN, DEBUG, SEND_DEBUG};
    assign bus.O_CPU_EN    = ((state_q == RUN) && !bus.I_HALT) || step_q;
    assign bus.O_SEND_REQ  = send_req_q;
    assign bus.O_ERR       = err && !RESET;
endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: table-driven and randomized program loads checked against a
// byte-stream model, plus hand sequences for run, step, bad command and reset corner cases.
module tb_uart_program_loader;
    localparam int PM_ADDR_W = 5;
    localparam int DEPTH     = 1 << PM_ADDR_W;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    uart_program_loader_if #(.PM_ADDR_W(PM_ADDR_W)) ifc ();

    uart_program_loader #(
        .PM_ADDR_W     (PM_ADDR_W),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (ifc.master)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [PM_ADDR_W-1:0] addr;
        logic [31:0]          data;
        int                   at_edge;
    } wr_t;

    typedef struct {
        int n;
        bit zero_prefix;
        int exp_writes;
        int exp_errs;
    } ld_vec_t;

    wr_t        wr_log[$];
    int         consume_edges[$];
    int         cpu_en_edges[$];
    int         send_req_edges[$];
    int         err_obs;
    logic [7:0] rx_q[$];
    int         edge_no;
    logic       rd_seen;
    int         checks;
    int         errors;

    function automatic void drive_rx();
        ifc.I_RX_EMPTY = (rx_q.size() == 0);
        ifc.I_RX_DATA  = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    endfunction

    // RX FIFO model: a byte leaves the queue on the edge where O_RD_UART was high.
    always @(posedge CLK) begin
        edge_no++;
        rd_seen = ifc.O_RD_UART;
        #1;
        if (rd_seen) begin
            if (rx_q.size() > 0) void'(rx_q.pop_front());
            consume_edges.push_back(edge_no);
            drive_rx();
        end
    end

    always @(negedge CLK) begin
        if (ifc.O_PM_WR)    wr_log.push_back('{ifc.O_PM_ADDR, ifc.O_PM_DATA, edge_no});
        if (ifc.O_CPU_EN)   cpu_en_edges.push_back(edge_no);
        if (ifc.O_SEND_REQ) send_req_edges.push_back(edge_no);
        if (ifc.O_ERR)      err_obs++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        wr_log.delete();
        consume_edges.delete();
        cpu_en_edges.delete();
        send_req_edges.delete();
        err_obs = 0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        rx_q.delete();
        drive_rx();
        tick();
        RESET = 1'b0;
        clear_logs();
    endtask

    task automatic send_bytes(input logic [7:0] b[$]);
        for (int i = 0; i < b.size(); i++) begin
            rx_q.push_back(b[i]);
            drive_rx();
            if (i != b.size() - 1) repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic send1(input logic [7:0] v);
        rx_q.push_back(v);
        drive_rx();
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (rx_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        chk({tag, "_drain"}, 64'(rx_q.size()), 0);
    endtask

    // Model: word k is bytes 4k..4k+3 after the count byte, MSB first; only the first DEPTH words land in PM.
    task automatic run_load(input int n, input bit zero_prefix, input int exp_w, input int exp_e, input string tag);
        logic [7:0]  b[$];
        logic [31:0] words[$];
        int          base;
        do_reset();
        if (zero_prefix) b.push_back(8'h00);
        b.push_back(8'(n));
        for (int k = 0; k < n; k++) begin
            logic [31:0] w;
            w = $urandom;
            words.push_back(w);
            for (int j = 3; j >= 0; j--) b.push_back(w[8*j +: 8]);
        end
        send_bytes(b);
        wait_drain(tag);
        repeat (3) tick();
        base = zero_prefix ? 1 : 0;
        chk({tag, "_writes"}, 64'(wr_log.size()), 64'(exp_w));
        for (int k = 0; k < exp_w && k < wr_log.size(); k++) begin
            chk($sformatf("%s_addr%0d", tag, k), 64'(wr_log[k].addr), 64'(k % DEPTH));
            chk($sformatf("%s_data%0d", tag, k), 64'(wr_log[k].data), 64'(words[k]));
            if (base + 4*k + 4 < consume_edges.size())
                chk($sformatf("%s_lat%0d", tag, k), 64'(wr_log[k].at_edge), 64'(consume_edges[base + 4*k + 4]));
        end
        chk({tag, "_err"}, 64'(err_obs), 64'(exp_e));
        chk({tag, "_load_done"}, 64'(ifc.O_LOAD_DONE), 1);
    endtask

    initial begin
        ld_vec_t     tbl[5];
        logic [7:0]  fixed[$];
        int          n;
        int          rn;

        tbl = '{
            '{1,  1'b0, 1,  0},
            '{34, 1'b0, 32, 1},
            '{32, 1'b1, 32, 1},
            '{33, 1'b1, 32, 2},
            '{7,  1'b0, 7,  0}
        };

        checks = 0;
        errors = 0;
        edge_no = 0;
        ifc.I_HALT      = 1'b0;
        ifc.I_SEND_DONE = 1'b0;
        drive_rx();
        repeat (2) tick();

        // Reset state
        do_reset();
        chk("rst_rd",        64'(ifc.O_RD_UART),   0);
        chk("rst_pm_wr",     64'(ifc.O_PM_WR),     0);
        chk("rst_pm_addr",   64'(ifc.O_PM_ADDR),   0);
        chk("rst_pm_data",   64'(ifc.O_PM_DATA),   0);
        chk("rst_load_done", 64'(ifc.O_LOAD_DONE), 0);
        chk("rst_cpu_en",    64'(ifc.O_CPU_EN),    0);
        chk("rst_send_req",  64'(ifc.O_SEND_REQ),  0);
        chk("rst_err",       64'(ifc.O_ERR),       0);

        // Two-word program from the reference stream
        fixed = {8'h02, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20};
        send_bytes(fixed);
        wait_drain("fix");
        repeat (3) tick();
        chk("fix_writes", 64'(wr_log.size()), 2);
        if (wr_log.size() == 2 && consume_edges.size() >= 9) begin
            chk("fix_addr0", 64'(wr_log[0].addr), 0);
            chk("fix_data0", 64'(wr_log[0].data), 64'h8C010004);
            chk("fix_lat0",  64'(wr_log[0].at_edge), 64'(consume_edges[4]));
            chk("fix_addr1", 64'(wr_log[1].addr), 1);
            chk("fix_data1", 64'(wr_log[1].data), 64'h00221820);
            chk("fix_lat1",  64'(wr_log[1].at_edge), 64'(consume_edges[8]));
        end
        chk("fix_load_done", 64'(ifc.O_LOAD_DONE), 1);
        chk("fix_err", 64'(err_obs), 0);

        for (int i = 0; i < 5; i++)
            run_load(tbl[i].n, tbl[i].zero_prefix, tbl[i].exp_writes, tbl[i].exp_errs, $sformatf("tbl%0d", i));

        for (int i = 0; i < 4; i++) begin
            rn = $urandom_range(1, 40);
            run_load(rn, 1'b0, (rn < DEPTH) ? rn : DEPTH, (rn > DEPTH) ? 1 : 0, $sformatf("rnd%0d", i));
        end

        // Bad command in WAIT_OP, then RUN with halt after 20 enabled cycles
        run_load(1, 1'b0, 1, 0, "run");
        send1(8'h78);
        wait_drain("badcmd");
        tick();
        chk("badcmd_err", 64'(err_obs), 1);
        chk("badcmd_load_done", 64'(ifc.O_LOAD_DONE), 1);
        chk("badcmd_cpu_en", 64'(cpu_en_edges.size()), 0);
        send1(8'h72);
        n = 0;
        while (cpu_en_edges.size() == 0 && n < 50) begin
            tick();
            n++;
        end
        chk("run_started", 64'(cpu_en_edges.size() > 0), 1);
        repeat (19) tick();
        ifc.I_HALT = 1'b1;
        n = 0;
        while (send_req_edges.size() == 0 && n < 20) begin
            tick();
            n++;
        end
        repeat (4) tick();
        chk("run_cpu_cycles", 64'(cpu_en_edges.size()), 20);
        if (cpu_en_edges.size() > 0)
            chk("run_contiguous", 64'(cpu_en_edges[$] - cpu_en_edges[0]), 19);
        chk("run_send_req", 64'(send_req_edges.size()), 1);
        chk("run_cpu_en_halted", 64'(ifc.O_CPU_EN), 0);
        chk("run_load_done_send", 64'(ifc.O_LOAD_DONE), 1);
        ifc.I_SEND_DONE = 1'b1;
        tick();
        ifc.I_SEND_DONE = 1'b0;
        ifc.I_HALT = 1'b0;
        tick();
        chk("run_done_load_done", 64'(ifc.O_LOAD_DONE), 0);
        chk("run_done_send_req", 64'(send_req_edges.size()), 1);
        send1(8'h00);
        wait_drain("run_waitn");
        tick();
        chk("run_waitn_err", 64'(err_obs), 2);

        // Debug mode: three single steps, last one with halt to leave
        run_load(1, 1'b0, 1, 0, "dbg");
        send1(8'h64);
        wait_drain("dbg_cmd");
        send1(8'h41);
        wait_drain("dbg_other");
        repeat (3) tick();
        chk("dbg_idle_cpu_en", 64'(cpu_en_edges.size()), 0);
        chk("dbg_other_err", 64'(err_obs), 0);
        for (int i = 0; i < 3; i++) begin
            send1(8'h73);
            n = 0;
            while (send_req_edges.size() < i + 1 && n < 50) begin
                tick();
                n++;
            end
            repeat (3) tick();
            chk($sformatf("dbg_step%0d_cpu_en", i), 64'(cpu_en_edges.size()), 64'(i + 1));
            chk($sformatf("dbg_step%0d_send_req", i), 64'(send_req_edges.size()), 64'(i + 1));
            if (cpu_en_edges.size() == i + 1 && send_req_edges.size() == i + 1)
                chk($sformatf("dbg_step%0d_order", i), 64'(send_req_edges[i] - cpu_en_edges[i]), 1);
            if (i == 2) ifc.I_HALT = 1'b1;
            ifc.I_SEND_DONE = 1'b1;
            tick();
            ifc.I_SEND_DONE = 1'b0;
            tick();
            ifc.I_HALT = 1'b0;
        end
        chk("dbg_total_cpu_en", 64'(cpu_en_edges.size()), 3);
        chk("dbg_exit_load_done", 64'(ifc.O_LOAD_DONE), 0);

        // Reset after two bytes of the second word
        do_reset();
        fixed = {8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_bytes(fixed);
        wait_drain("rstmid");
        repeat (2) tick();
        chk("rstmid_pre_writes", 64'(wr_log.size()), 1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("rstmid_pm_wr", 64'(ifc.O_PM_WR), 0);
        chk("rstmid_load_done", 64'(ifc.O_LOAD_DONE), 0);
        repeat (4) tick();
        chk("rstmid_writes", 64'(wr_log.size()), 1);
        send1(8'h00);
        wait_drain("rstmid_waitn");
        tick();
        chk("rstmid_waitn_err", 64'(err_obs), 1);

`ifdef LOADER_TIMEOUT_EN
        do_reset();
        fixed = {8'h01, 8'hAA, 8'hBB};
        send_bytes(fixed);
        wait_drain("to");
        repeat (110) tick();
        chk("to_err", 64'(err_obs), 1);
        chk("to_writes", 64'(wr_log.size()), 0);
        send1(8'h00);
        wait_drain("to_waitn");
        tick();
        chk("to_waitn_err", 64'(err_obs), 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Receive-side counterpart of the debug unit's UART transmit path.
- Pops bytes from the UART RX FIFO (`rd_uart`/`rx_empty`/`r_data`) and reads the instruction count.
- Assembles 32-bit instructions MSB-first and writes them into MIPS program memory.
- Then accepts a RUN or DEBUG command and gates CPU execution, handing off to the debug unit for state dumps.

Parameters:
- PM_ADDR_W, 5: program memory word-address width; depth = 2**PM_ADDR_W.
- CMD_RUN, 8'h72: command byte 'r', selects continuous run.
- CMD_DEBUG, 8'h64: command byte 'd', selects step mode.
- CMD_STEP, 8'h73: command byte 's', executes one cycle in step mode.
- TIMEOUT_CYCLES, 50000000: inter-byte timeout; used only with the optional feature.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- I_RX_EMPTY  in  1  UART RX FIFO empty.
- I_RX_DATA  in  8  UART RX FIFO head byte; valid whenever I_RX_EMPTY=0.
- O_RD_UART  out  1  pop strobe to the RX FIFO.
- O_PM_WR  out  1  program memory write strobe (maps to I_MIPS_WrPM).
- O_PM_ADDR  out  PM_ADDR_W  program memory word address.
- O_PM_DATA  out  32  instruction word (maps to I_MIPS_WrDataPM).
- O_LOAD_DONE  out  1  level: program loaded, in WAIT_OP or later.
- O_CPU_EN  out  1  MIPS pipeline clock-enable.
- I_HALT  in  1  MIPS reached its halt instruction; level.
- O_SEND_REQ  out  1  one-cycle pulse: debug unit must dump state.
- I_SEND_DONE  in  1  one-cycle pulse: debug unit finished the dump.
- O_ERR  out  1  one-cycle pulse on a protocol error.

Behaviour:
- States: WAIT_N, RECEIVE_INSTR, LOAD_PM, WAIT_OP, RUN, SEND_RUN, DEBUG, SEND_DEBUG.
- Reset: state=WAIT_N; all outputs, the word counter, byte counter and shift register are 0.
- Byte consume:
  - O_RD_UART = (state ∈ {WAIT_N, RECEIVE_INSTR, WAIT_OP, DEBUG}) && !I_RX_EMPTY && !RESET. It is combinational.
  - The byte is sampled from I_RX_DATA on the same edge; the FIFO pops on that edge.
  - At most one byte is consumed per cycle.
- WAIT_N:
  - Byte 0 is ignored; stay in WAIT_N and pulse O_ERR.
  - Otherwise latch N (8 bits), clear counters, go to RECEIVE_INSTR.
- RECEIVE_INSTR:
  - Each byte does shreg <= {shreg[23:0], byte}; byte counter 0..3.
  - On the 4th byte go to LOAD_PM.
- LOAD_PM (exactly 1 cycle):
  - If word_idx < 2**PM_ADDR_W: O_PM_WR=1, O_PM_ADDR=word_idx[PM_ADDR_W-1:0], O_PM_DATA=shreg.
  - Otherwise no write: words beyond depth are consumed and discarded, and O_ERR pulses once at the first such word.
  - word_idx increments.
  - If word_idx+1 == N go to WAIT_OP; else return to RECEIVE_INSTR.
  - Write latency: 1 cycle after the edge that consumed the 4th byte.
- WAIT_OP:
  - O_LOAD_DONE=1.
  - CMD_RUN goes to RUN; CMD_DEBUG goes to DEBUG.
  - Any other byte is discarded with an O_ERR pulse; stay in WAIT_OP.
- RUN:
  - O_CPU_EN=1 while I_HALT=0.
  - When I_HALT=1 (sampled), O_CPU_EN=0 in that same cycle (combinational gate); go to SEND_RUN and pulse O_SEND_REQ on entry.
- SEND_RUN:
  - O_CPU_EN=0; wait for I_SEND_DONE, then go to WAIT_N.
  - O_LOAD_DONE drops to 0 on entry to WAIT_N.
- DEBUG:
  - O_CPU_EN=0; RX bytes are still consumed.
  - CMD_STEP: O_CPU_EN=1 for exactly the next cycle, then O_SEND_REQ pulses the cycle after, and the state is SEND_DEBUG.
  - Other bytes are discarded silently.
- SEND_DEBUG: on I_SEND_DONE, go to WAIT_N if I_HALT=1, else back to DEBUG.
- RX FIFO is not read in LOAD_PM, RUN, SEND_RUN or SEND_DEBUG; bytes arriving then stay queued.
- I_SEND_DONE outside SEND_* states is ignored. I_HALT outside RUN/SEND_DEBUG is ignored.
- RESET mid-load or mid-run returns to WAIT_N on the next edge; partial words are dropped and no PM write is issued.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- When defined:
  - A 26-bit counter runs in RECEIVE_INSTR, cleared on every consumed byte.
  - Reaching TIMEOUT_CYCLES-1 aborts to WAIT_N, pulses O_ERR and clears the counters.
  - PM words already written remain.
- When undefined: no counter; RECEIVE_INSTR waits indefinitely.

Test Plan:
- N=2, bytes 8C 01 00 04 / 00 22 18 20:
  - O_PM_WR pulses twice: addr0=0x8C010004, addr1=0x00221820.
  - Each pulse comes 1 cycle after the 4th byte of its word.
  - Then O_LOAD_DONE=1.
- Load N=1, then 'r' with I_HALT asserted 20 cycles later:
  - O_CPU_EN high for 20 cycles, then 0.
  - Single O_SEND_REQ pulse.
  - After I_SEND_DONE the state is WAIT_N and O_LOAD_DONE=0.
- Load, then 'd', then 's' ×3 with I_SEND_DONE after each request:
  - Exactly 3 single-cycle O_CPU_EN pulses.
  - Each followed next cycle by an O_SEND_REQ pulse.
- N=0x22 with PM_ADDR_W=5:
  - 32 writes to addresses 0..31.
  - Words 33–34 consumed with no write; one O_ERR pulse.
  - Ends in WAIT_OP.
- 'x' (0x78) in WAIT_OP: O_ERR pulse, remains in WAIT_OP; a following 'r' enters RUN.
- RESET asserted after 2 bytes of a word: next edge gives WAIT_N, no O_PM_WR. With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=100, a 100-cycle gap mid-word gives an O_ERR pulse and WAIT_N.
